// File: rtl/core_control_multi.sv
// Store/transfer/process sequencer that dispatches work round-robin across NUM_PU units.
// Watchdog-guarded waits on the memory controller and the units, with a sticky error state.
module core_control_multi #(
  parameter int ADDR_W    = 6,
  parameter int NUM_PU    = 4,
  parameter int MEM_DEPTH = 64,
  parameter int TIMEOUT   = 255,
  parameter int CNT_W     = 7,
  localparam int SEL_W    = (NUM_PU > 1) ? $clog2(NUM_PU) : 1
) (
  input  logic              ctrl_clk,
  input  logic              ctrl_reset,
  input  logic [4:0]        ctrl_instruction,
  input  logic [ADDR_W-1:0] ctrl_data_address_in,
  input  logic              ctrl_valid_inst,
  input  logic              ctrl_valid_data,
  input  logic              ctrl_last_data,
  input  logic              ctrl_err_clr,
  input  logic              mc_err,
  input  logic              mc_cont_procc,
  input  logic              mc_data_done,
  input  logic [NUM_PU-1:0] procc_done,
  output logic [ADDR_W-1:0] mc_data_address_out,
  output logic              mc_we,
  output logic [3:0]        ctrl_data_contition,
  output logic [NUM_PU-1:0] procc_start,
  output logic [4:0]        ctrl_inst_out,
  output logic [SEL_W-1:0]  ctrl_pu_sel,
  output logic [CNT_W-1:0]  ctrl_word_count,
  output logic              ctrl_busy,
  output logic              ctrl_error
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, STORE_DATA, TRANS_DATA, START_PROC, DONE_PROC, ERROR
  } state_t;

  state_t              state, state_nxt;
  logic [WD_W-1:0]     wd, wd_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic                we_nxt;
  logic [3:0]          cond_nxt;
  logic [NUM_PU-1:0]   start_nxt;
  logic [4:0]          inst_nxt;
  logic [SEL_W-1:0]    sel_nxt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                wd_exp;
  logic                done_sel;

  assign wd_exp   = (wd == WD_W'(TIMEOUT - 1));
  assign done_sel = |(procc_done & (NUM_PU'(1) << ctrl_pu_sel));

  always_ff @(posedge ctrl_clk) begin
    if (ctrl_reset) begin
      state               <= IDLE;
      wd                  <= '0;
      mc_data_address_out <= '0;
      mc_we               <= 1'b0;
      ctrl_data_contition <= '0;
      procc_start         <= '0;
      ctrl_inst_out       <= '0;
      ctrl_pu_sel         <= '0;
      ctrl_word_count     <= '0;
      ctrl_busy           <= 1'b0;
      ctrl_error          <= 1'b0;
    end else begin
      state               <= state_nxt;
      wd                  <= wd_nxt;
      mc_data_address_out <= addr_nxt;
      mc_we               <= we_nxt;
      ctrl_data_contition <= cond_nxt;
      procc_start         <= start_nxt;
      ctrl_inst_out       <= inst_nxt;
      ctrl_pu_sel         <= sel_nxt;
      ctrl_word_count     <= cnt_nxt;
      ctrl_busy           <= (state_nxt != IDLE);
      ctrl_error          <= (state_nxt == ERROR);
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = mc_data_address_out;
    we_nxt    = 1'b0;
    cond_nxt  = ctrl_data_contition;
    start_nxt = '0;
    inst_nxt  = ctrl_inst_out;
    sel_nxt   = ctrl_pu_sel;
    cnt_nxt   = ctrl_word_count;
    case (state)
      IDLE:
        if (ctrl_valid_inst && ctrl_valid_data) begin
          inst_nxt = ctrl_instruction;
          addr_nxt = ctrl_data_address_in;
          cnt_nxt  = CNT_W'(1);
          if (ctrl_last_data) begin
            state_nxt = TRANS_DATA;
            cond_nxt  = 4'b1100;
          end else begin
            state_nxt = STORE_DATA;
            we_nxt    = 1'b1;
          end
        end
      STORE_DATA:
        if (mc_err) begin
          state_nxt = ERROR;
        end else if (ctrl_valid_data) begin
          // A non-last word with the buffer already full would overrun memory.
          if (!ctrl_last_data && ctrl_word_count == CNT_W'(MEM_DEPTH)) begin
            state_nxt = ERROR;
          end else begin
            addr_nxt = mc_data_address_out + 1'b1;
            cnt_nxt  = ctrl_word_count + 1'b1;
            if (ctrl_last_data) begin
              state_nxt = TRANS_DATA;
              cond_nxt  = 4'b1100;
            end else begin
              we_nxt = 1'b1;
            end
          end
        end
      TRANS_DATA:
        if (mc_cont_procc) begin
          state_nxt = START_PROC;
          cond_nxt  = 4'b1111;
          start_nxt = NUM_PU'(1) << ctrl_pu_sel;
        end else if (wd_exp) begin
          state_nxt = ERROR;
        end
      START_PROC:
        if (done_sel) begin
          state_nxt = DONE_PROC;
          cond_nxt  = 4'b1110;
          sel_nxt   = (ctrl_pu_sel == SEL_W'(NUM_PU - 1)) ? '0 : ctrl_pu_sel + 1'b1;
        end else if (wd_exp) begin
          state_nxt = ERROR;
        end
      DONE_PROC:
        if (mc_data_done) begin
          state_nxt = IDLE;
          cond_nxt  = 4'b0000;
        end else if (mc_cont_procc) begin
          state_nxt = TRANS_DATA;
        end else begin
          state_nxt = IDLE;
        end
      ERROR:
        if (ctrl_err_clr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == ERROR) begin
      we_nxt    = 1'b0;
      start_nxt = '0;
      cond_nxt  = 4'b0000;
    end
    wd_nxt = '0;
    if (state_nxt == state && (state == TRANS_DATA || state == START_PROC))
      wd_nxt = wd + 1'b1;
  end

endmodule

// File: tb/tb_core_control_multi.sv
// Directed scoreboard bench for core_control_multi: expectations queued per step, checked after each edge.
module tb_core_control_multi;
  localparam int ADDR_W = 6, NUM_PU = 4, MEM_DEPTH = 64, TIMEOUT = 255, CNT_W = 7, SEL_W = 2;
  localparam int A = 0, WE = 1, CD = 2, ST = 3, ER = 4, BZ = 5, CN = 6, SL = 7, IN = 8;

  logic              ctrl_clk = 1'b0;
  logic              ctrl_reset = 1'b1;
  logic [4:0]        ctrl_instruction = '0;
  logic [ADDR_W-1:0] ctrl_data_address_in = '0;
  logic              ctrl_valid_inst = 1'b0, ctrl_valid_data = 1'b0, ctrl_last_data = 1'b0;
  logic              ctrl_err_clr = 1'b0, mc_err = 1'b0, mc_cont_procc = 1'b0, mc_data_done = 1'b0;
  logic [NUM_PU-1:0] procc_done = '0;
  logic [ADDR_W-1:0] mc_data_address_out;
  logic              mc_we;
  logic [3:0]        ctrl_data_contition;
  logic [NUM_PU-1:0] procc_start;
  logic [4:0]        ctrl_inst_out;
  logic [SEL_W-1:0]  ctrl_pu_sel;
  logic [CNT_W-1:0]  ctrl_word_count;
  logic              ctrl_busy, ctrl_error;

  int checks = 0;
  int errors = 0;
  string       tq[$];
  int          sq[$];
  logic [31:0] vq[$];

  core_control_multi #(.ADDR_W(ADDR_W), .NUM_PU(NUM_PU), .MEM_DEPTH(MEM_DEPTH),
                       .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .ctrl_clk(ctrl_clk), .ctrl_reset(ctrl_reset), .ctrl_instruction(ctrl_instruction),
    .ctrl_data_address_in(ctrl_data_address_in), .ctrl_valid_inst(ctrl_valid_inst),
    .ctrl_valid_data(ctrl_valid_data), .ctrl_last_data(ctrl_last_data),
    .ctrl_err_clr(ctrl_err_clr), .mc_err(mc_err), .mc_cont_procc(mc_cont_procc),
    .mc_data_done(mc_data_done), .procc_done(procc_done),
    .mc_data_address_out(mc_data_address_out), .mc_we(mc_we),
    .ctrl_data_contition(ctrl_data_contition), .procc_start(procc_start),
    .ctrl_inst_out(ctrl_inst_out), .ctrl_pu_sel(ctrl_pu_sel),
    .ctrl_word_count(ctrl_word_count), .ctrl_busy(ctrl_busy), .ctrl_error(ctrl_error)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  function automatic logic [31:0] obs(int s);
    case (s)
      A:  return 32'(mc_data_address_out);
      WE: return 32'(mc_we);
      CD: return 32'(ctrl_data_contition);
      ST: return 32'(procc_start);
      ER: return 32'(ctrl_error);
      BZ: return 32'(ctrl_busy);
      CN: return 32'(ctrl_word_count);
      SL: return 32'(ctrl_pu_sel);
      default: return 32'(ctrl_inst_out);
    endcase
  endfunction

  task automatic ex(string t, int s, logic [31:0] v);
    tq.push_back(t); sq.push_back(s); vq.push_back(v);
  endtask

  task automatic ex_zero(string t);
    for (int s = A; s <= IN; s++) ex(t, s, 32'd0);
  endtask

  // Advance one edge, then retire every queued expectation against the settled outputs.
  task automatic step();
    string t;
    int s;
    logic [31:0] e, o;
    @(posedge ctrl_clk); #1;
    while (vq.size() > 0) begin
      t = tq.pop_front(); s = sq.pop_front(); e = vq.pop_front(); o = obs(s);
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s sig=%0d observed=%0h expected=%0h", t, s, o, e);
      end
    end
  endtask

  task automatic run_proc(int sel);
    repeat (2) begin ex("trans_wait_cond", CD, 32'hC); ex("trans_wait_start", ST, 0); step(); end
    mc_cont_procc = 1'b1;
    ex("proc_cond_F", CD, 32'hF); ex("proc_start", ST, 32'(1) << sel); step();
    mc_cont_procc = 1'b0;
    ex("start_one_cycle", ST, 0); ex("proc_cond_hold", CD, 32'hF); step();
    procc_done = NUM_PU'(1) << sel;
    ex("done_cond_E", CD, 32'hE); ex("sel_advance", SL, 32'((sel + 1) % NUM_PU)); step();
    procc_done = '0; mc_data_done = 1'b1;
    ex("end_cond_0", CD, 0); ex("end_idle", BZ, 0); step();
    mc_data_done = 1'b0;
  endtask

  task automatic start_single(logic [ADDR_W-1:0] a, logic [4:0] ins);
    ctrl_valid_inst = 1'b1; ctrl_valid_data = 1'b1; ctrl_last_data = 1'b1;
    ctrl_data_address_in = a; ctrl_instruction = ins;
    ex("single_addr", A, 32'(a)); ex("single_we0", WE, 0); ex("single_cond", CD, 32'hC);
    ex("single_cnt", CN, 1); ex("single_inst", IN, 32'(ins)); ex("single_busy", BZ, 1);
    step();
    ctrl_valid_inst = 1'b0; ctrl_valid_data = 1'b0; ctrl_last_data = 1'b0;
  endtask

  task automatic clear_err();
    ctrl_err_clr = 1'b1; ex("clr_err", ER, 0); ex("clr_idle", BZ, 0); step();
    ctrl_err_clr = 1'b0;
  endtask

  initial begin
    // Reset
    ctrl_reset = 1'b1; step();
    ex_zero("reset"); step();
    ctrl_reset = 1'b0;

    // 6 words from 0x3C, address wraps
    ctrl_valid_inst = 1'b1; ctrl_valid_data = 1'b1; ctrl_data_address_in = 6'h3C;
    ctrl_instruction = 5'h15;
    ex("w1_addr", A, 32'h3C); ex("w1_we", WE, 1); ex("w1_cnt", CN, 1); ex("w1_inst", IN, 32'h15);
    ex("w1_busy", BZ, 1); step();
    ctrl_valid_inst = 1'b0; ctrl_instruction = 5'h00;
    for (int i = 2; i <= 5; i++) begin
      ex("wn_addr", A, (32'h3C + 32'(i) - 1) % 64); ex("wn_we", WE, 1); ex("wn_cnt", CN, 32'(i));
      step();
    end
    ctrl_last_data = 1'b1;
    ex("w6_addr", A, 32'h01); ex("w6_we0", WE, 0); ex("w6_cnt", CN, 6); ex("w6_cond", CD, 32'hC);
    ex("w6_inst_held", IN, 32'h15); step();
    ctrl_valid_data = 1'b0; ctrl_last_data = 1'b0;
    run_proc(0);

    // Two more round-robin transactions
    ctrl_valid_inst = 1'b1; ctrl_valid_data = 1'b1; ctrl_data_address_in = 6'h08;
    ex("t2_addr", A, 32'h08); ex("t2_we", WE, 1); step();
    ctrl_valid_inst = 1'b0; ctrl_last_data = 1'b1;
    ex("t2_last_addr", A, 32'h09); ex("t2_cnt", CN, 2); ex("t2_cond", CD, 32'hC); step();
    ctrl_valid_data = 1'b0; ctrl_last_data = 1'b0;
    run_proc(1);
    start_single(6'h20, 5'h0B);
    run_proc(2);

    // mc_err wins over last
    ctrl_valid_inst = 1'b1; ctrl_valid_data = 1'b1; ctrl_data_address_in = 6'h11;
    ex("e_w1_we", WE, 1); step();
    ctrl_valid_inst = 1'b0; ctrl_last_data = 1'b1; mc_err = 1'b1;
    ex("mcerr_err", ER, 1); ex("mcerr_we0", WE, 0); ex("mcerr_cond", CD, 0); ex("mcerr_busy", BZ, 1);
    ex("mcerr_addr_hold", A, 32'h11); step();
    ctrl_valid_data = 1'b0; ctrl_last_data = 1'b0; mc_err = 1'b0;
    ex("err_sticky", ER, 1); step();
    clear_err();
    ex("sel_preserved", SL, 3); step();

    // Watchdog in TRANS_DATA
    start_single(6'h00, 5'h01);
    repeat (TIMEOUT - 2) step();
    ex("trans_wd_before", ER, 0); ex("trans_wd_busy", BZ, 1); step();
    ex("trans_wd_err", ER, 1); ex("trans_wd_cond", CD, 0); step();
    clear_err();

    // Wrong-unit done ignored, then timeout in START_PROC
    start_single(6'h02, 5'h02);
    mc_cont_procc = 1'b1;
    ex("sp_start", ST, 32'h8); step();
    mc_cont_procc = 1'b0; procc_done = 4'b0111;
    ex("wrong_done_cond", CD, 32'hF); ex("wrong_done_sel", SL, 3); step();
    repeat (TIMEOUT - 3) step();
    ex("sp_wd_before", ER, 0); step();
    ex("sp_wd_err", ER, 1); ex("sp_wd_start", ST, 0); ex("sp_wd_sel", SL, 3); step();
    procc_done = '0;
    clear_err();

    // Done on the expiring cycle beats the timeout
    start_single(6'h03, 5'h03);
    mc_cont_procc = 1'b1; step();
    mc_cont_procc = 1'b0;
    repeat (TIMEOUT - 2) step();
    ex("tie_before", ER, 0); step();
    procc_done = 4'b1000;
    ex("tie_no_err", ER, 0); ex("tie_cond", CD, 32'hE); ex("tie_sel", SL, 0); step();
    procc_done = '0; mc_data_done = 1'b1;
    ex("tie_idle", BZ, 0); step();
    mc_data_done = 1'b0;

    // Overflow: word MEM_DEPTH+1 without last
    ctrl_valid_inst = 1'b1; ctrl_valid_data = 1'b1; ctrl_data_address_in = 6'h10;
    ex("ovf_w1_cnt", CN, 1); step();
    ctrl_valid_inst = 1'b0;
    for (int i = 2; i <= MEM_DEPTH; i++) begin
      ex("ovf_we", WE, 1); ex("ovf_cnt", CN, 32'(i)); step();
    end
    ex("ovf_err", ER, 1); ex("ovf_we0", WE, 0); ex("ovf_cnt_hold", CN, 64); ex("ovf_addr", A, 32'h0F);
    step();
    ctrl_valid_data = 1'b0;
    clear_err();

    // Reset mid-store, then a fresh transaction
    ctrl_valid_inst = 1'b1; ctrl_valid_data = 1'b1; ctrl_data_address_in = 6'h2A;
    ctrl_instruction = 5'h1F; step();
    ctrl_valid_inst = 1'b0; step();
    ctrl_reset = 1'b1;
    ex_zero("mid_reset"); step();
    ctrl_reset = 1'b0; ctrl_valid_data = 1'b0;
    start_single(6'h05, 5'h0A);
    run_proc(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/core_control_multi.md
Name: core_control_multi

Overview:
- Parametrised successor to the single-unit core control FSM.
- Sequences store-to-memory, memory-to-register transfer and processing across NUM_PU processing units, dispatched round-robin.
- Adds an auto-incrementing write address, a stored-word counter, a watchdog timeout and a sticky error state.
- Sits between the input interface, the memory controller (mc_*) and the processing-unit array.

Parameters:
- ADDR_W, 6, width of memory address buses.
- NUM_PU, 4, number of processing units (≥1).
- MEM_DEPTH, 64, maximum words storable per transaction (≤ 2^ADDR_W).
- TIMEOUT, 255, maximum cycles allowed in TRANS_DATA or START_PROC before error.
- CNT_W, 7, stored-word counter width (must hold MEM_DEPTH).

Ports:
- ctrl_clk  in  1  clock, rising edge.
- ctrl_reset  in  1  synchronous, active-high reset.
- ctrl_instruction  in  5  [FPU_OP|ROUND_MODE]; latched on start.
- ctrl_data_address_in  in  ADDR_W  start address.
- ctrl_valid_inst  in  1  instruction valid.
- ctrl_valid_data  in  1  data word valid this cycle.
- ctrl_last_data  in  1  final data word of transaction.
- ctrl_err_clr  in  1  clears ERROR state.
- mc_err  in  1  memory controller reports memory full.
- mc_cont_procc  in  1  memory controller: registers loaded, processing may start.
- mc_data_done  in  1  memory controller: all stored data consumed.
- procc_done  in  NUM_PU  per-unit done pulse.
- mc_data_address_out  out  ADDR_W  current write address.
- mc_we  out  1  memory write enable.
- ctrl_data_contition  out  4  [HAS_DATA|VALID_DATA|HAS_DATA_R|VALID_DATA_R].
- procc_start  out  NUM_PU  one-hot start to the selected unit.
- ctrl_inst_out  out  5  latched instruction.
- ctrl_pu_sel  out  clog2(NUM_PU) (min 1)  selected unit index.
- ctrl_word_count  out  CNT_W  words stored this transaction.
- ctrl_busy  out  1  high in any state except IDLE.
- ctrl_error  out  1  high in ERROR.

Behaviour:
- Reset is synchronous and active-high. In the cycle after ctrl_reset is sampled high:
  - all outputs are 0;
  - state is IDLE;
  - the round-robin pointer is 0;
  - the watchdog is 0.
  - Reset overrides every state, including mid-transfer.
- All outputs are registered. States: IDLE, STORE_DATA, TRANS_DATA, START_PROC, DONE_PROC, ERROR.
- IDLE:
  - If ctrl_valid_inst && ctrl_valid_data: latch ctrl_instruction into ctrl_inst_out, load mc_data_address_out ← ctrl_data_address_in, set mc_we=1 and ctrl_word_count=1, then go to STORE_DATA.
  - The first word is written at the start address.
  - If ctrl_last_data is also high in that cycle, go directly to TRANS_DATA with mc_we=0, contition=1100 and word_count=1.
- STORE_DATA:
  - Each cycle with ctrl_valid_data=1: address +1 (wraps modulo 2^ADDR_W), word_count +1, mc_we=1.
  - Each cycle with ctrl_valid_data=0: mc_we=0, address holds.
  - On a valid word with ctrl_last_data: mc_we=0 next cycle, contition=1100, go to TRANS_DATA.
  - mc_err=1, or a valid non-last word arriving with word_count==MEM_DEPTH, goes to ERROR with mc_we=0. mc_err takes priority over last.
- TRANS_DATA:
  - The watchdog counts cycles.
  - mc_cont_procc=1: contition=1111, procc_start[pu_sel]=1 for exactly one cycle, clear watchdog, go to START_PROC.
  - Watchdog reaching TIMEOUT goes to ERROR.
- START_PROC:
  - Waits for procc_done[pu_sel]; done bits from other units are ignored.
  - On done: contition=1110, pu_sel ← (pu_sel+1) mod NUM_PU, go to DONE_PROC.
  - Watchdog reaching TIMEOUT goes to ERROR.
  - If done arrives in the same cycle the timeout expires, done wins.
- DONE_PROC (one cycle):
  - If mc_data_done=1: contition=0000, go to IDLE. This has priority.
  - Else if mc_cont_procc=1: go to TRANS_DATA.
  - Else: go to IDLE.
- ERROR:
  - ctrl_error=1, mc_we=0, procc_start=0, contition=0000.
  - Stays until ctrl_err_clr=1, then goes to IDLE.
  - The pointer is preserved.
- The watchdog clears on every state change.

Test Plan:
- Reset, then start addr=0x3C with 6 valid words, last on the 6th → addresses 3C,3D,3E,3F,00,01 (wrap); ctrl_word_count=6; mc_we low the cycle after last; contition=1100.
- 3 full transactions, each with mc_cont_procc after 2 cycles and procc_done on the selected unit, then mc_data_done → procc_start one-hot 0001, 0010, 0100; contition sequence 1100→1111→1110→0000; one cycle per pulse.
- In STORE_DATA, assert mc_err together with ctrl_last_data → ERROR, ctrl_error=1; ctrl_err_clr → IDLE the next cycle.
- Hold mc_cont_procc low for TIMEOUT cycles in TRANS_DATA → ERROR after exactly TIMEOUT cycles; wrong-unit procc_done in START_PROC is ignored and times out the same way.
- MEM_DEPTH+1 valid words without last → ERROR on word MEM_DEPTH+1; mc_we never asserted for that word.
- Assert ctrl_reset mid-STORE_DATA → next cycle all outputs 0 and state IDLE; a new transaction starts normally.
